// File: rtl/control_multiciclo_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and the ALU control decoder.
// Optional jump support is enabled by defining CONTROL_JUMP_EN.
package control_multiciclo_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 3;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] SW_LW   = 3'b000;
  localparam logic [ALUOP_W-1:0] BRANQ_E = 3'b001;
  localparam logic [ALUOP_W-1:0] TIPO_R  = 3'b010;
  localparam logic [ALUOP_W-1:0] ADDI    = 3'b011;
  localparam logic [ALUOP_W-1:0] ORI     = 3'b100;
  localparam logic [ALUOP_W-1:0] ANDI    = 3'b101;
  localparam logic [ALUOP_W-1:0] SLTI    = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
`ifdef CONTROL_JUMP_EN
    S_JUMP     = 4'd12,
`endif
    S_BRANCH   = 4'd11
  } state_t;

  // Compact tag for the immediate ALU op, kept across EXEC_I
  typedef enum logic [1:0] {
    IMM_ADD = 2'd0,
    IMM_OR  = 2'd1,
    IMM_AND = 2'd2,
    IMM_SLT = 2'd3
  } imm_sel_t;

  function automatic imm_sel_t imm_sel_of(
    input logic [OPCODE_W-1:0] op
  );
    unique case (op)
      OP_ORI:  return IMM_OR;
      OP_ANDI: return IMM_AND;
      OP_SLTI: return IMM_SLT;
      default: return IMM_ADD;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] imm_alu_op(
    input imm_sel_t sel
  );
    unique case (sel)
      IMM_OR:  return ORI;
      IMM_AND: return ANDI;
      IMM_SLT: return SLTI;
      default: return ADDI;
    endcase
  endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// Control bundle between the multi-cycle FSM (master)
// and the datapath/memory (slave).
interface control_multiciclo_if;
  import control_multiciclo_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic                i_or_d;
  logic                ir_write;
  logic                pc_write;
  logic                pc_write_cond;
  logic [1:0]          pc_src;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                illegal;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write,
    output pc_write, pc_write_cond, pc_src,
    output alu_src_a, alu_src_b, alu_op,
    output reg_write, reg_dst, mem_to_reg, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write,
    input  pc_write, pc_write_cond, pc_src,
    input  alu_src_a, alu_src_b, alu_op,
    input  reg_write, reg_dst, mem_to_reg, illegal
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS main control FSM.
// Define CONTROL_JUMP_EN to add the j instruction (S_JUMP).
module control_multiciclo
  import control_multiciclo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  control_multiciclo_if.master bus
);

  state_t   state, state_n;
  imm_sel_t imm_sel;
  logic     is_lw;
  logic     op_legal;

  always_comb begin
    op_legal = 1'b0;
    unique case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI:
        op_legal = 1'b1;
`ifdef CONTROL_JUMP_EN
      OP_J: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      imm_sel <= IMM_ADD;
      is_lw   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        imm_sel <= imm_sel_of(bus.opcode);
        is_lw   <= (bus.opcode == OP_LW);
      end
    end
  end

  always_comb begin
    state_n = S_IDLE;
    unique case (state)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:
        state_n = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_RTYPE:        state_n = S_EXEC_R;
          OP_LW, OP_SW:    state_n = S_MEM_ADDR;
          OP_BEQ:          state_n = S_BRANCH;
          OP_ADDI, OP_ORI,
          OP_ANDI, OP_SLTI: state_n = S_EXEC_I;
`ifdef CONTROL_JUMP_EN
          OP_J:            state_n = S_JUMP;
`endif
          default:         state_n = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_n = S_WB_R;
      S_WB_R:     state_n = S_FETCH;
      S_EXEC_I:   state_n = S_WB_I;
      S_WB_I:     state_n = S_FETCH;
      S_MEM_ADDR:
        state_n = is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        state_n = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:
        state_n = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_MEM:   state_n = S_FETCH;
      S_BRANCH:   state_n = S_FETCH;
`ifdef CONTROL_JUMP_EN
      S_JUMP:     state_n = S_FETCH;
`endif
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = SW_LW;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.illegal       = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.illegal   = !op_legal;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = TIPO_R;
      end
      S_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = imm_alu_op(imm_sel);
      end
      S_WB_I:   bus.reg_write = 1'b1;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = BRANQ_E;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
      end
`ifdef CONTROL_JUMP_EN
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo.
// Honours CONTROL_JUMP_EN for the jump vectors.
module tb_control_multiciclo;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } out_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    int          len;
    out_t [4:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  out_t exp_q[$];
  out_t got;
  vec_t tbl[$];

  control_multiciclo_if bus ();

  control_multiciclo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign got = {bus.mem_req, bus.mem_we, bus.i_or_d,
                bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src,
                bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg,
                bus.illegal};

  function automatic out_t e_fetch(input logic rdy);
    out_t e = '0;
    e.mem_req = 1'b1;
    e.alu_src_b = 2'b01;
    e.ir_write = rdy;
    e.pc_write = rdy;
    return e;
  endfunction

  function automatic out_t e_dec(input logic ill);
    out_t e = '0;
    e.alu_src_b = 2'b11;
    e.illegal = ill;
    return e;
  endfunction

  function automatic out_t e_exec(input logic [1:0] b,
                                  input logic [2:0] aop);
    out_t e = '0;
    e.alu_src_a = 1'b1;
    e.alu_src_b = b;
    e.alu_op = aop;
    return e;
  endfunction

  function automatic out_t e_wb(input logic dst,
                                input logic m2r);
    out_t e = '0;
    e.reg_write = 1'b1;
    e.reg_dst = dst;
    e.mem_to_reg = m2r;
    return e;
  endfunction

  function automatic out_t e_mem(input logic we);
    out_t e = '0;
    e.mem_req = 1'b1;
    e.i_or_d = 1'b1;
    e.mem_we = we;
    return e;
  endfunction

  function automatic out_t e_br();
    out_t e = '0;
    e.alu_src_a = 1'b1;
    e.alu_op = 3'b001;
    e.pc_write_cond = 1'b1;
    e.pc_src = 2'b01;
    return e;
  endfunction

  function automatic out_t e_jmp();
    out_t e = '0;
    e.pc_write = 1'b1;
    e.pc_src = 2'b10;
    return e;
  endfunction

  function automatic vec_t mkv(
    input string n, input logic [5:0] op, input int len,
    input out_t a, input out_t b, input out_t c,
    input out_t d, input out_t f);
    vec_t v;
    v.name = n;
    v.op = op;
    v.len = len;
    v.exp[0] = a;
    v.exp[1] = b;
    v.exp[2] = c;
    v.exp[3] = d;
    v.exp[4] = f;
    return v;
  endfunction

  task automatic check(input string nm);
    out_t e;
    e = exp_q.pop_front();
    total++;
    if (got === e) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, e);
  endtask

  task automatic step(input logic rdy, input logic [5:0] op,
                      input out_t e, input string nm);
    bus.mem_ready = rdy;
    bus.opcode = op;
    exp_q.push_back(e);
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_t z;
    z = '0;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'b0;

    tbl.push_back(mkv("rtype", 6'b000000, 4, e_fetch(1),
      e_dec(0), e_exec(2'b00, 3'b010), e_wb(1, 0), z));
    tbl.push_back(mkv("lw", 6'b100011, 5, e_fetch(1),
      e_dec(0), e_exec(2'b10, 3'b000), e_mem(0), e_wb(0, 1)));
    tbl.push_back(mkv("sw", 6'b101011, 4, e_fetch(1),
      e_dec(0), e_exec(2'b10, 3'b000), e_mem(1), z));
    tbl.push_back(mkv("beq", 6'b000100, 3, e_fetch(1),
      e_dec(0), e_br(), z, z));
    tbl.push_back(mkv("addi", 6'b001000, 4, e_fetch(1),
      e_dec(0), e_exec(2'b10, 3'b011), e_wb(0, 0), z));
    tbl.push_back(mkv("ori", 6'b001101, 4, e_fetch(1),
      e_dec(0), e_exec(2'b10, 3'b100), e_wb(0, 0), z));
    tbl.push_back(mkv("andi", 6'b001100, 4, e_fetch(1),
      e_dec(0), e_exec(2'b10, 3'b101), e_wb(0, 0), z));
    tbl.push_back(mkv("slti", 6'b001010, 4, e_fetch(1),
      e_dec(0), e_exec(2'b10, 3'b110), e_wb(0, 0), z));
    tbl.push_back(mkv("illegal", 6'b111111, 2, e_fetch(1),
      e_dec(1), z, z, z));
`ifdef CONTROL_JUMP_EN
    tbl.push_back(mkv("jump", 6'b000010, 3, e_fetch(1),
      e_dec(0), e_jmp(), z, z));
`else
    tbl.push_back(mkv("jump_ill", 6'b000010, 2, e_fetch(1),
      e_dec(1), z, z, z));
`endif

    #3;
    exp_q.push_back(z);
    check("reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 6'b000000, z, "idle_after_reset");

    for (int i = 0; i < tbl.size(); i++)
      for (int k = 0; k < tbl[i].len; k++)
        step(1'b1, tbl[i].op, tbl[i].exp[k],
             $sformatf("%s.c%0d", tbl[i].name, k));

    // fetch stall, then lw with two wait cycles in MEM_RD
    step(1'b0, 6'b100011, e_fetch(0), "fetch_wait");
    step(1'b1, 6'b100011, e_fetch(1), "lw_w.fetch");
    step(1'b1, 6'b100011, e_dec(0), "lw_w.dec");
    step(1'b1, 6'b100011, e_exec(2'b10, 3'b000), "lw_w.addr");
    step(1'b0, 6'b100011, e_mem(0), "lw_w.wait1");
    step(1'b0, 6'b100011, e_mem(0), "lw_w.wait2");
    step(1'b1, 6'b100011, e_mem(0), "lw_w.rd");
    step(1'b1, 6'b100011, e_wb(0, 1), "lw_w.wb");

    // ori whose opcode input changes after decode
    step(1'b1, 6'b001101, e_fetch(1), "ori_chg.fetch");
    step(1'b1, 6'b001101, e_dec(0), "ori_chg.dec");
    step(1'b1, 6'b000000, e_exec(2'b10, 3'b100), "ori_chg.exec");
    step(1'b1, 6'b000000, e_wb(0, 0), "ori_chg.wb");

    // sw with one wait cycle
    step(1'b1, 6'b101011, e_fetch(1), "sw_w.fetch");
    step(1'b1, 6'b101011, e_dec(0), "sw_w.dec");
    step(1'b1, 6'b101011, e_exec(2'b10, 3'b000), "sw_w.addr");
    step(1'b0, 6'b101011, e_mem(1), "sw_w.wait");
    step(1'b1, 6'b101011, e_mem(1), "sw_w.wr");

    // reset asserted while a load waits on memory
    step(1'b1, 6'b100011, e_fetch(1), "rst_lw.fetch");
    step(1'b1, 6'b100011, e_dec(0), "rst_lw.dec");
    step(1'b1, 6'b100011, e_exec(2'b10, 3'b000), "rst_lw.addr");
    bus.mem_ready = 1'b0;
    exp_q.push_back(e_mem(0));
    @(negedge clk);
    check("rst_lw.wait");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(z);
    check("rst_lw.async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 6'b000000, z, "rst_lw.idle");
    step(1'b0, 6'b000000, e_fetch(0), "rst_lw.fetch2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Multi-cycle main control FSM for the MIPS datapath.
- Decodes the 6-bit instruction opcode and sequences fetch, decode, execute, memory and write-back over several clocks.
- Drives the datapath enables/selects and the 3-bit alu_op bus that feeds the ALU control decoder; it is the producer end of that bus.
- Instruction/data memory is shared and accessed through a req/ready handshake.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 3, width of the alu_op output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26]; sampled in S_DECODE.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access request.
- mem_we  output  1  write strobe, valid with mem_req.
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  output  1  load instruction register.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- pc_src  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alu_src_a  output  1  ALU A select: 0=PC, 1=rs.
- alu_src_b  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- alu_op  output  3  to ALU control: 000 lw/sw, 001 beq, 010 R-type, 011 addi, 100 ori, 101 andi, 110 slti.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  write register select: 0=rt, 1=rd.
- mem_to_reg  output  1  write data select: 0=ALUOut, 1=MDR.
- illegal  output  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset:
  - Async on rst_n low; state goes to S_IDLE.
  - All outputs are 0 in S_IDLE, including alu_op=000.
- Output timing:
  - Outputs are combinational from the current state.
  - ir_write and pc_write in S_FETCH, and the MEM-state exits, are additionally qualified by mem_ready.
  - Any output not listed for a state is 0.
- S_IDLE: goes to S_FETCH on the next clock, unconditionally.
- S_FETCH:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1 and pc_write=1 that cycle, then S_DECODE.
- S_DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Dispatch on opcode:
    - 000000 goes to S_EXEC_R.
    - 100011 and 101011 go to S_MEM_ADDR.
    - 000100 goes to S_BRANCH.
    - 001000, 001101, 001100 and 001010 go to S_EXEC_I.
    - Any other opcode: illegal=1 for this cycle, then S_FETCH.
- S_EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010; then S_WB_R.
- S_WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; then S_FETCH.
- S_EXEC_I:
  - alu_src_a=1, alu_src_b=10.
  - alu_op per opcode: 011 addi, 100 ori, 101 andi, 110 slti.
  - The decoded opcode is latched into a 2-bit register in S_DECODE; the opcode input is not required to stay stable after S_DECODE.
  - Then S_WB_I.
- S_WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; then S_FETCH.
- S_MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=000.
  - Goes to S_MEM_RD for lw, S_MEM_WR for sw; the lw/sw choice is latched in S_DECODE.
- S_MEM_RD: mem_req=1, i_or_d=1; holds until mem_ready, then S_WB_MEM.
- S_MEM_WR: mem_req=1, mem_we=1, i_or_d=1; holds until mem_ready, then S_FETCH.
- S_WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; then S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01; then S_FETCH.
- Latency, counting from S_FETCH entry with mem_ready=1 on first request:
  - R-type and I-type arithmetic: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each mem_ready=0 cycle adds 1.
- Boundaries:
  - mem_ready high outside S_FETCH/S_MEM_RD/S_MEM_WR is ignored.
  - rst_n low mid-wait aborts the access; mem_req drops asynchronously.
  - Unreachable state encodings go to S_IDLE.

Optional Feature:
- Macro CONTROL_JUMP_EN.
- Defined:
  - Opcode 000010 goes from S_DECODE to S_JUMP.
  - S_JUMP drives pc_write=1, pc_src=10, then S_FETCH; 3-cycle latency.
- Undefined: S_JUMP does not exist, and 000010 is treated as illegal (illegal pulse, then S_FETCH).

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_J);
  - alu_op codes (TIPO_R=010, SW_LW=000, BRANQ_E=001, ADDI=011, ORI=100, ANDI=101, SLTI=110);
  - the state encoding.
- These are shared with the ALU control decoder, so the alu_op encoding is defined in one place.
- No sub-module is required; the FSM and output decode stay in one module.

Test Plan:
- Reset: rst_n=0 mid-S_MEM_RD -> mem_req=0 immediately, all outputs 0; after release, S_IDLE then S_FETCH with mem_req=1, alu_src_b=01.
- R-type: opcode=000000, mem_ready=1 always -> S_EXEC_R cycle shows alu_op=010; reg_write=1 with reg_dst=1 on cycle 4; next cycle is S_FETCH.
- lw with memory wait: opcode=100011, mem_ready low 2 cycles in S_MEM_RD -> mem_req=1, i_or_d=1 held; reg_write=1 with mem_to_reg=1 at cycle 7.
- I-type: ori opcode=001101 changed to 000000 after S_DECODE -> S_EXEC_I still drives alu_op=100, alu_src_b=10.
- beq: opcode=000100 -> S_BRANCH shows alu_op=001, pc_write_cond=1, pc_src=01; back to S_FETCH after 3 cycles.
- Illegal/jump: opcode=000010 -> illegal=1 for one cycle without CONTROL_JUMP_EN; with it, pc_write=1, pc_src=10, illegal=0.
